// File: rtl/pipeline_chain.sv
// pipeline_chain: pipeline register chain with per-stage valid, stall/bubble, flush and saturating counters
module pipeline_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          retired_cnt,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          flush_events
);
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] squash;
    logic              retire;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             v;
        logic [WIDTH-1:0] d;
        assign hold[k]   = |stall[STAGES-1:k];
        assign squash[k] = |flush[STAGES-1:k];
        assign stage_valid[k] = v;
        assign stage_data[k*WIDTH +: WIDTH] = d;
        if (k == 0) begin : g_head
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    v <= 1'b0;
                    d <= '0;
                end else if (squash[k]) begin
                    v <= 1'b0;
                end else if (!hold[k]) begin
                    v <= in_valid;
                    d <= in_data;
                end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    v <= 1'b0;
                    d <= '0;
                end else if (squash[k]) begin
                    v <= 1'b0;
                end else if (!hold[k]) begin
                    v <= hold[k-1] ? 1'b0 : stage_valid[k-1];
                    d <= hold[k-1] ? d : stage_data[(k-1)*WIDTH +: WIDTH];
                end
        end
    end
    assign in_ready  = ~hold[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];
    assign retire    = stage_valid[STAGES-1] & ~hold[STAGES-1] & ~squash[STAGES-1];
    always_ff @(posedge clk or posedge rst)
        if (rst || cnt_clr) begin
            retired_cnt  <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (retire && !(&retired_cnt)) retired_cnt <= retired_cnt + CNT_W'(1);
            if ((|stall) && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
            if ((|flush) && !(&flush_events)) flush_events <= flush_events + CNT_W'(1);
        end
endmodule
